// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: button indices and the
// auto-repeat state encoding used by btn_conditioner.
package timer_pkg;

   localparam int unsigned BTN_UP     = 0;
   localparam int unsigned BTN_DOWN   = 1;
   localparam int unsigned BTN_LEFT   = 2;
   localparam int unsigned BTN_RIGHT  = 3;
   localparam int unsigned BTN_ACTION = 4;
   localparam int unsigned NUM_BTN    = 5;

   typedef enum logic [1:0] {
      RptIdle   = 2'b00,
      RptDelay  = 2'b01,
      RptRepeat = 2'b10
   } rpt_state_e;

   // Counter width able to hold n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button channel: two-flop synchroniser, debounce counter and registered
// press/release edge pulses aligned with the level change.
module btn_debounce_cell
   import timer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            level_q, level_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            press_q, press_d;
   logic            release_q, release_d;

   always_comb begin
      sync1_d = raw_i;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         level_q   <= 1'b0;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the five raw push-buttons into clean debounced levels and pulses.
// Define BTN_AUTO_REPEAT_EN to add auto-repeat on the up/down buttons.
module btn_conditioner
   import timer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 5000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release
);

   logic [NUM_BTN-1:0] edge_press;

   if (DEBOUNCE_CYCLES < 2 || REPEAT_RATE < 1 || REPEAT_DELAY < 1) begin : g_bad_param
      $error("btn_conditioner: illegal parameter value");
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
      btn_debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw_i    (btn_raw[i]),
         .level_o  (btn_level[i]),
         .press_o  (edge_press[i]),
         .release_o(btn_release[i])
      );
   end

`ifdef BTN_AUTO_REPEAT_EN
   localparam int unsigned RptW =
      cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

   rpt_state_e      state_q [2];
   rpt_state_e      state_d [2];
   logic [RptW-1:0] rcnt_q  [2];
   logic [RptW-1:0] rcnt_d  [2];
   logic [1:0]      rpt_pulse;

   // Repeat pulses are decoded from registered state, so they sit in the same
   // cycle as the counter match and vanish as soon as the level drops.
   always_comb begin
      for (int b = BTN_UP; b <= BTN_DOWN; b++) begin
         state_d[b]   = state_q[b];
         rcnt_d[b]    = rcnt_q[b];
         rpt_pulse[b] = 1'b0;
         if (!btn_level[b]) begin
            state_d[b] = RptIdle;
            rcnt_d[b]  = '0;
         end else begin
            unique case (state_q[b])
               RptIdle: begin
                  if (edge_press[b]) begin
                     state_d[b] = RptDelay;
                     rcnt_d[b]  = '0;
                  end
               end
               RptDelay: begin
                  if (rcnt_q[b] == RptW'(REPEAT_DELAY - 1)) begin
                     rpt_pulse[b] = 1'b1;
                     state_d[b]   = RptRepeat;
                     rcnt_d[b]    = '0;
                  end else begin
                     rcnt_d[b] = rcnt_q[b] + RptW'(1);
                  end
               end
               RptRepeat: begin
                  if (rcnt_q[b] == RptW'(REPEAT_RATE - 1)) begin
                     rpt_pulse[b] = 1'b1;
                     rcnt_d[b]    = '0;
                  end else begin
                     rcnt_d[b] = rcnt_q[b] + RptW'(1);
                  end
               end
               default: begin
                  state_d[b] = RptIdle;
                  rcnt_d[b]  = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            state_q[b] <= RptIdle;
            rcnt_q[b]  <= '0;
         end
      end else begin
         for (int b = 0; b < 2; b++) begin
            state_q[b] <= state_d[b];
            rcnt_q[b]  <= rcnt_d[b];
         end
      end
   end

   assign btn_press = edge_press | {{(NUM_BTN - 2){1'b0}}, rpt_pulse};
`else
   assign btn_press = edge_press;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed table, reset-mid-hold
// sequence and randomized stimulus against a sample-history reference model.
module tb_btn_conditioner;

   localparam int Deb      = 4;
   localparam int RptDly   = 20;
   localparam int RptRate  = 5;
`ifdef BTN_AUTO_REPEAT_EN
   localparam bit RptEn = 1'b1;
`else
   localparam bit RptEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] btn_raw;
   logic [4:0] btn_level;
   logic [4:0] btn_press;
   logic [4:0] btn_release;

   always #5 clk = ~clk;

   btn_conditioner #(
      .DEBOUNCE_CYCLES(Deb),
      .REPEAT_DELAY   (RptDly),
      .REPEAT_RATE    (RptRate)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: level flips once the raw samples taken 2..Deb+1 edges
   // ago all disagree with it; repeats follow from time held since the rise.
   logic [4:0] hist [Deb+1];
   logic [4:0] m_lvl, m_press, m_rel, nl;
   int         held [5];
   bit         all_diff;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j <= Deb; j++) hist[j] = '0;
         for (int b = 0; b < 5; b++) held[b] = 0;
         m_lvl   = '0;
         m_press = '0;
         m_rel   = '0;
      end else begin
         nl = m_lvl;
         for (int b = 0; b < 5; b++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= Deb; j++) if (hist[j][b] == m_lvl[b]) all_diff = 1'b0;
            if (all_diff) nl[b] = ~m_lvl[b];
         end
         for (int j = Deb; j >= 1; j--) hist[j] = hist[j-1];
         hist[0] = btn_raw;
         m_press = nl & ~m_lvl;
         m_rel   = ~nl & m_lvl;
         for (int b = 0; b < 5; b++) begin
            if (m_press[b]) held[b] = 0;
            else if (nl[b]) held[b] = held[b] + 1;
            if (RptEn && b < 2 && nl[b] && !m_press[b] && held[b] >= RptDly &&
                (held[b] - RptDly) % RptRate == 0) m_press[b] = 1'b1;
         end
         m_lvl = nl;
      end
   end

   int pc [5];
   int rc [5];

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_n(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("model level", btn_level, m_lvl);
      chk("model press", btn_press, m_press);
      chk("model release", btn_release, m_rel);
      for (int b = 0; b < 5; b++) begin
         if (btn_press[b]) pc[b]++;
         if (btn_release[b]) rc[b]++;
      end
   endtask

   function automatic logic [4:0][7:0] cnt5(input int c4, c3, c2, c1, c0);
      return {8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
   endfunction

   typedef struct {
      logic [4:0]      raw;
      int              hold;
      logic [4:0]      lvl;
      logic [4:0][7:0] pn;
      logic [4:0][7:0] rn;
   } row_t;

   row_t rows [10];
   int   first;
   int   gap;

   initial begin
      int r1, r0;
      r1 = RptEn ? 1 : 0;
      rows[0] = '{5'b10000, 30, 5'b10000, cnt5(1, 0, 0, 0, 0), cnt5(0, 0, 0, 0, 0)};
      rows[1] = '{5'b00000, 10, 5'b00000, cnt5(0, 0, 0, 0, 0), cnt5(1, 0, 0, 0, 0)};
      rows[2] = '{5'b00100, 3,  5'b00000, cnt5(0, 0, 0, 0, 0), cnt5(0, 0, 0, 0, 0)};
      rows[3] = '{5'b00000, 3,  5'b00000, cnt5(0, 0, 0, 0, 0), cnt5(0, 0, 0, 0, 0)};
      rows[4] = '{5'b00100, 3,  5'b00000, cnt5(0, 0, 0, 0, 0), cnt5(0, 0, 0, 0, 0)};
      rows[5] = '{5'b00000, 10, 5'b00000, cnt5(0, 0, 0, 0, 0), cnt5(0, 0, 0, 0, 0)};
      r0 = 1 + 6 * r1;
      rows[6] = '{5'b00001, 55, 5'b00001, cnt5(0, 0, 0, 0, r0), cnt5(0, 0, 0, 0, 0)};
      rows[7] = '{5'b00000, 10, 5'b00000, cnt5(0, 0, 0, 0, r1), cnt5(0, 0, 0, 0, 1)};
      rows[8] = '{5'b00011, 30, 5'b00011, cnt5(0, 0, 0, 1 + r1, 1 + r1), cnt5(0, 0, 0, 0, 0)};
      rows[9] = '{5'b00000, 10, 5'b00000, cnt5(0, 0, 0, r1, r1), cnt5(0, 0, 0, 1, 1)};

      btn_raw = '0;
      rst_n   = 1'b0;
      #1;
      chk("reset level", btn_level, 5'b0);
      chk("reset press", btn_press, 5'b0);
      chk("reset release", btn_release, 5'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         btn_raw = rows[i].raw;
         for (int b = 0; b < 5; b++) begin
            pc[b] = 0;
            rc[b] = 0;
         end
         for (int k = 0; k < rows[i].hold; k++) tick();
         chk($sformatf("row%0d level", i), btn_level, rows[i].lvl);
         for (int b = 0; b < 5; b++) begin
            chk_n($sformatf("row%0d press count bit%0d", i, b), pc[b], int'(rows[i].pn[b]));
            chk_n($sformatf("row%0d release count bit%0d", i, b), rc[b], int'(rows[i].rn[b]));
         end
      end

      // Reset while down is held in its repeat phase.
      btn_raw = 5'b00010;
      repeat (31) tick();
      chk("pre-reset level held", btn_level, 5'b00010);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset level", btn_level, 5'b0);
      chk("async reset press", btn_press, 5'b0);
      chk("async reset release", btn_release, 5'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      first = -1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (first < 0 && btn_press[1]) first = k;
      end
      chk_n("post-reset press latency", first, Deb + 1);
      gap = -1;
      for (int k = 20; k < 45; k++) begin
         tick();
         if (gap < 0 && btn_press[1]) gap = k - first;
      end
      chk_n("post-reset first repeat gap", gap, RptEn ? RptDly : -1);
      btn_raw = '0;
      repeat (10) tick();

      // Randomized bouncing on all five buttons, with one mid-run reset.
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 5; b++) begin
            if ($urandom_range(0, 15) == 0) btn_raw[b] = ~btn_raw[b];
         end
         if (i == 1500) begin
            #3 rst_n = 1'b0;
            #1 chk("random async reset level", btn_level, 5'b0);
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the five raw push-buttons (up, down, left, right, action) before they reach the countdown timer/state controller.
- Per button: synchroniser, debouncer and single-cycle press pulse.
- Up/down additionally auto-repeat while held, so the set-up digits can be scrolled.
- Sits between the board pins and the timer block. The timer consumes only clean `clk`-synchronous pulses and never sees raw asynchronous inputs.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles an input must stay stable before it is accepted (10 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000, cycles from the accepted press until the first auto-repeat pulse (0.5 s).
- REPEAT_RATE, 5000000, cycles between subsequent auto-repeat pulses (0.1 s); must be >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  5  raw active-high buttons; bit0 up, bit1 down, bit2 left, bit3 right, bit4 action.
- btn_level  output  5  debounced level, same bit order.
- btn_press  output  5  one-cycle pulse per accepted press (plus repeats on bits 0-1).
- btn_release  output  5  one-cycle pulse per accepted release.

Behaviour:
- Reset:
  - The interface is fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.
  - Asserting `rst_n` low clears all synchroniser flops, debounce counters, repeat counters, `btn_level`, `btn_press` and `btn_release` to 0 immediately.
  - Release of reset takes effect at the next clock edge.
  - Reset mid-press: all state is discarded. A button still held after reset must re-qualify for DEBOUNCE_CYCLES and then produces a fresh press pulse.
- Synchroniser:
  - Two-flop chain per bit.
  - `sync` is the output of the second flop.
- Debounce (per bit):
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - If `sync == level`, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and `sync` still differs, `level` toggles on that edge and the counter clears.
  - Any bounce back to the old value before that point clears the counter; glitches shorter than DEBOUNCE_CYCLES are never seen.
- Latency:
  - A clean raw edge held steady changes `btn_level` exactly DEBOUNCE_CYCLES+2 cycles later.
  - `btn_press`/`btn_release` are registered and assert in the same cycle `btn_level` changes.
- Edge pulses:
  - `btn_press[i]` = `level` rising (registered compare with the previous level).
  - `btn_release[i]` = `level` falling.
  - Each pulse is exactly one cycle high.
- Auto-repeat (bits 0 and 1 only, when enabled):
  - Per-bit FSM with states IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on a press pulse; the counter loads 0.
  - DELAY: the counter counts to REPEAT_DELAY-1, then emits one `btn_press` pulse and goes to REPEAT with the counter at 0.
  - REPEAT: a pulse every REPEAT_RATE cycles.
  - `level` low in any state returns to IDLE on the same edge and no pulse is emitted that cycle.
  - Repeat pulses OR with edge pulses; they never coincide by construction.
  - Counter width is $clog2(REPEAT_DELAY) and must hold REPEAT_DELAY-1.
- Bits 2-4 never repeat. Action must give exactly one pulse per physical press, since the timer toggles run/stop on it.
- Simultaneous buttons:
  - All five channels are fully independent.
  - Any combination of pulses may assert in the same cycle; no priority is applied here.

Optional Feature:
- Macro BTN_AUTO_REPEAT_EN.
- Defined: the auto-repeat FSMs for bits 0-1 are instantiated as above.
- Undefined:
  - No repeat logic is synthesised.
  - `btn_press` on all bits is the pure rising-edge pulse.
  - REPEAT_DELAY and REPEAT_RATE are ignored.

Decomposition:
- Shared package `timer_pkg`:
  - Button index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_ACTION=4, and NUM_BTN=5.
  - Repeat FSM state encoding: IDLE=2'b00, DELAY=2'b01, REPEAT=2'b10.
  - The timer block imports the same indices.
- One sub-module, `btn_debounce_cell`: synchroniser, debounce counter and edge detect for a single bit, parameterised by DEBOUNCE_CYCLES.
  - Instantiated five times by generate.
  - Repeat FSM logic stays in the top.

Test Plan (sim parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5):
- Clean press: `btn_raw[4]` 0->1 held 30 cycles, then released and held 0 for 10 cycles.
  - `btn_level[4]` rises exactly 6 cycles after the edge.
  - One `btn_press[4]` pulse coincides with that rise.
  - No further press pulses while held.
  - `btn_release[4]` pulses 6 cycles after the falling edge.
- Bounce rejection: `btn_raw[2]` toggles 1,0,1,0 with each value held 3 cycles, then sits at 0.
  - `btn_level[2]` stays 0.
  - No pulse on `btn_press[2]` or `btn_release[2]`.
- Auto-repeat: `btn_raw[0]` held for 60 cycles with the macro defined.
  - Edge press pulse at t0.
  - Repeat pulses at t0+20, t0+25, ... t0+50 (7 pulses in total).
  - Releasing stops repeats immediately.
  - With the macro undefined, exactly 1 pulse.
- Simultaneous: `btn_raw` = 5'b00011 applied in one cycle.
  - `btn_press[0]` and `btn_press[1]` pulse in the same cycle.
  - Repeat trains stay phase-aligned.
- Reset mid-hold: `btn_raw[1]` held, `rst_n` pulsed low during the repeat phase.
  - All outputs 0 asynchronously while `rst_n` is low.
  - After release, a new press pulse appears 6 cycles later.
  - Repeats restart from REPEAT_DELAY.
